// File: rtl/pipeline_spi_master_if.sv
// rtl/pipeline_spi_master_if.sv - command/response bundle for pipeline_spi_master
// Purpose: groups the command handshake, the response pulse and busy into one port.
// Ports (signals):
//   cmd_valid, cmd_ready       command frame handshake
//   cmd_opcode[7:0]            first byte on the wire
//   cmd_payload[8*MAX_BYTES]   payload, byte 0 in bits [7:0] goes out first
//   cmd_len[2:0]               payload byte count
//   rsp_valid                  one-cycle frame-done pulse
//   rsp_data[8*(MAX_BYTES+1)]  captured MISO bits, right-aligned
//   busy                       high from acceptance until rsp_valid
// Modports: master = command issuer, slave = the SPI master block.
interface pipeline_spi_master_if #(
  parameter int MAX_BYTES = 4
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [7:0]                   cmd_opcode;
  logic [8*MAX_BYTES-1:0]       cmd_payload;
  logic [2:0]                   cmd_len;
  logic                         rsp_valid;
  logic [8*(MAX_BYTES+1)-1:0]   rsp_data;
  logic                         busy;

  modport master (
    output cmd_valid, cmd_opcode, cmd_payload, cmd_len,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_payload, cmd_len,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/pipeline_spi_master.sv
// rtl/pipeline_spi_master.sv - SPI mode-0 master writing the pipeline hw_spi_* control interface
// Purpose: accepts one frame (opcode + 0..MAX_BYTES payload bytes), shifts it out MSB-first,
//   captures MISO in parallel and returns the captured bits with a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   bus (slave)     command handshake, response pulse/data, busy
//   hw_spi_clk      SCK, idle low
//   hw_spi_ss       slave select, active low
//   hw_spi_mosi     master out
//   hw_spi_miso     master in, 2-flop synchronised
//   loopback        only with PIPELINE_SPI_MASTER_LOOPBACK_EN: capture own MOSI instead of MISO
// Configuration macro: PIPELINE_SPI_MASTER_LOOPBACK_EN
module pipeline_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_spi_master_if.slave    bus,
`ifdef PIPELINE_SPI_MASTER_LOOPBACK_EN
  input  logic                    loopback,
`endif
  output logic                    hw_spi_clk,
  output logic                    hw_spi_ss,
  output logic                    hw_spi_mosi,
  input  logic                    hw_spi_miso
);

  localparam int FW = 8 * (MAX_BYTES + 1);
  localparam int BW = $clog2(FW) + 1;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [2:0] MAX_LEN  = 3'(MAX_BYTES);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state;
  logic [7:0]    hcnt;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] nbits;
  logic [FW-1:0] sreg;
  logic [FW-1:0] rx;
  logic [FW-1:0] rsp_data_r;
  logic          rsp_valid_r;
  logic          sck;
  logic          ss;
  logic          miso_s1;
  logic          miso_s2;

  logic [2:0]    len_c;
  logic [FW-1:0] frame_c;
  logic [BW-1:0] nbits_c;
  logic          cmd_ready_c;
  logic          hcnt_last;
  logic          miso_bit;

  assign len_c       = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;
  assign nbits_c     = BW'({len_c, 3'b000}) + BW'(8);
  assign cmd_ready_c = (state == IDLE) && !rsp_valid_r;
  assign hcnt_last   = (hcnt == DIV_LAST);

  // Frame is left-aligned; bytes beyond len are zero so the register drains to 0,
  // which keeps MOSI low once the last bit has been shifted out.
  always_comb begin
    frame_c = '0;
    frame_c[FW-1 -: 8] = bus.cmd_opcode;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (3'(i) < len_c) frame_c[FW-9-8*i -: 8] = bus.cmd_payload[8*i +: 8];
    end
  end

`ifdef PIPELINE_SPI_MASTER_LOOPBACK_EN
  assign miso_bit = loopback ? sreg[FW-1] : miso_s2;
`else
  assign miso_bit = miso_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hcnt        <= '0;
      bcnt        <= '0;
      nbits       <= '0;
      sreg        <= '0;
      rx          <= '0;
      rsp_data_r  <= '0;
      rsp_valid_r <= 1'b0;
      sck         <= 1'b0;
      ss          <= 1'b1;
      miso_s1     <= 1'b0;
      miso_s2     <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      miso_s1     <= hw_spi_miso;
      miso_s2     <= miso_s1;
      if (state != IDLE) hcnt <= hcnt_last ? 8'd0 : hcnt + 8'd1;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_c) begin
            state <= SETUP;
            sreg  <= frame_c;
            nbits <= nbits_c;
            bcnt  <= '0;
            rx    <= '0;
            ss    <= 1'b0;
          end
        end
        SETUP: begin
          if (hcnt_last) begin
            state <= SHIFT;
            sck   <= 1'b1;
            rx    <= {rx[FW-2:0], miso_bit};
            bcnt  <= bcnt + BW'(1);
          end
        end
        SHIFT: begin
          if (hcnt_last) begin
            if (sck) begin
              sck  <= 1'b0;
              sreg <= {sreg[FW-2:0], 1'b0};
            end else if (bcnt == nbits) begin
              state <= HOLD;
            end else begin
              sck  <= 1'b1;
              rx   <= {rx[FW-2:0], miso_bit};
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        HOLD: begin
          if (hcnt_last) begin
            state <= GAP;
            ss    <= 1'b1;
            sreg  <= '0;
          end
        end
        GAP: begin
          if (hcnt_last) begin
            state       <= IDLE;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= rx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.busy      = (state != IDLE) || rsp_valid_r;
  assign hw_spi_clk    = sck;
  assign hw_spi_ss     = ss;
  assign hw_spi_mosi   = sreg[FW-1];

endmodule

// File: tb/tb_pipeline_spi_master.sv
// tb/tb_pipeline_spi_master.sv - directed scoreboard bench for pipeline_spi_master
module tb_pipeline_spi_master;
  localparam int CLK_DIV   = 2;
  localparam int MAX_BYTES = 4;

  logic clk = 1'b0;
  logic rst;
  logic sck, ss, mosi, miso;
  always #5 clk = ~clk;

  pipeline_spi_master_if #(.MAX_BYTES(MAX_BYTES)) bus();
`ifdef PIPELINE_SPI_MASTER_LOOPBACK_EN
  logic loopback;
`endif

  pipeline_spi_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst), .bus(bus),
`ifdef PIPELINE_SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .hw_spi_clk(sck), .hw_spi_ss(ss), .hw_spi_mosi(mosi), .hw_spi_miso(miso)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_popped = 0;

  logic [39:0] exp_rsp_q[$];
  logic [39:0] exp_wire_q[$];
  int          exp_bits_q[$];

  // Wire monitor and slave model, all sampled on the falling clk edge.
  int cyc = 0, fall_cyc = 0, ss_low = 0, rises = 0, frames = 0, rsp_seen = 0;
  int hi_run = 0, last_gap = 0, last_lat = 0, last_ss_low = 0, last_rises = 0;
  logic [39:0] mosi_word = '0, last_rsp = '0, last_mosi = '0, slave_pat = '0;
  logic prev_ss = 1'b1, prev_sck = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_ss && !ss) begin
      fall_cyc = cyc; ss_low = 0; rises = 0; mosi_word = '0; frames++; last_gap = hi_run;
    end
    if (!ss) begin ss_low++; hi_run = 0; end else hi_run++;
    if (!prev_sck && sck) begin rises++; mosi_word = {mosi_word[38:0], mosi}; end
    if (bus.rsp_valid) begin
      rsp_seen++; last_rsp = bus.rsp_data; last_mosi = mosi_word;
      last_lat = cyc - fall_cyc; last_ss_low = ss_low; last_rises = rises;
    end
    // Slave presents bit k after the k-th rise; bit 0 is held while ss is high.
    if (ss) miso = slave_pat[39];
    else if (rises < 40) miso = slave_pat[39-rises];
    else miso = 1'b0;
    prev_ss = ss; prev_sck = sck;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prep(input logic [7:0] op, input logic [31:0] pl, input logic [2:0] len,
                      input logic lb);
    int l;
    int n;
    logic [39:0] w;
    l = (len > 3'd4) ? 4 : int'(len);
    w = 40'(op);
    for (int i = 0; i < l; i++) w = (w << 8) | 40'(pl[8*i +: 8]);
    n = 8 * (l + 1);
    exp_wire_q.push_back(w);
    exp_bits_q.push_back(n);
    exp_rsp_q.push_back(lb ? w : (slave_pat >> (40 - n)));
    bus.cmd_opcode = op; bus.cmd_payload = pl; bus.cmd_len = len;
  endtask

  task automatic wait_accept(input string tag);
    int f0;
    int t;
    f0 = frames; t = 0;
    while (frames == f0 && t < 4000) begin @(posedge clk); t++; end
    #1;
    chk({tag, "_accept"}, 64'(frames), 64'(f0 + 1));
  endtask

  task automatic wait_rsp(input string tag);
    int t;
    int n;
    logic [39:0] er, ew;
    t = 0;
    while (rsp_seen <= n_popped && t < 4000) begin @(posedge clk); t++; end
    #1;
    chk({tag, "_rsp_seen"}, 64'(rsp_seen > n_popped), 64'd1);
    n_popped++;
    er = exp_rsp_q.pop_front(); ew = exp_wire_q.pop_front(); n = exp_bits_q.pop_front();
    chk({tag, "_rsp_data"}, 64'(last_rsp), 64'(er));
    chk({tag, "_mosi"}, 64'(last_mosi), 64'(ew));
    chk({tag, "_rises"}, 64'(last_rises), 64'(n));
    chk({tag, "_ss_low"}, 64'(last_ss_low), 64'((2*n + 2) * CLK_DIV));
    chk({tag, "_latency"}, 64'(last_lat), 64'((2*n + 3) * CLK_DIV));
  endtask

  initial begin
    logic lbv;
    int t;
    begin : watchdog_arm
      fork
        begin
          #2000000;
          $display("FAIL watchdog: simulation time limit reached");
          $fatal(1, "watchdog");
        end
      join_none
    end
    lbv = 1'b0;
`ifdef PIPELINE_SPI_MASTER_LOOPBACK_EN
    loopback = 1'b0;
`endif
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_payload = '0; bus.cmd_len = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_ss", 64'(ss), 64'd1);
    chk("rst_mosi", 64'(mosi), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: opcode A5, no payload, MISO all ones
    slave_pat = '1;
    prep(8'hA5, 32'h0, 3'd0, 1'b0);
    bus.cmd_valid = 1'b1;
    wait_accept("t1");
    bus.cmd_valid = 1'b0;
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_ready_low", 64'(bus.cmd_ready), 64'd0);
    wait_rsp("t1");
    chk("t1_ready_after", 64'(bus.cmd_ready), 64'd1);

    // T2: opcode 03, two payload bytes
    slave_pat = 40'h0;
    prep(8'h03, 32'h0000_1234, 3'd2, 1'b0);
    bus.cmd_valid = 1'b1;
    wait_accept("t2");
    bus.cmd_valid = 1'b0;
    wait_rsp("t2");

    // T3: slave returns 5A C3
    slave_pat = {16'h5AC3, 24'h0};
    prep(8'h11, 32'h0000_0066, 3'd1, 1'b0);
    bus.cmd_valid = 1'b1;
    wait_accept("t3");
    bus.cmd_valid = 1'b0;
    wait_rsp("t3");

    // T4: len 7 clamps to 4 bytes; cmd_valid held through the whole frame
    slave_pat = 40'h01_2345_6789;
    prep(8'h9C, 32'hDEAD_BEEF, 3'd7, 1'b0);
    t = frames;
    bus.cmd_valid = 1'b1;
    wait_accept("t4");
    wait_rsp("t4");
    bus.cmd_valid = 1'b0;
    chk("t4_single_accept", 64'(frames), 64'(t + 1));

    // T5: reset after five SCK rises aborts the frame
    slave_pat = 40'hFF_FF00_0000;
    prep(8'hF0, 32'h0000_5555, 3'd2, 1'b0);
    bus.cmd_valid = 1'b1;
    wait_accept("t5");
    bus.cmd_valid = 1'b0;
    t = 0;
    while (rises < 5 && t < 2000) begin @(posedge clk); t++; end
    #1;
    chk("t5_reached_5_rises", 64'(rises >= 5), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_ss_high", 64'(ss), 64'd1);
    chk("t5_sck_low", 64'(sck), 64'd0);
    chk("t5_ready", 64'(bus.cmd_ready), 64'd1);
    chk("t5_rsp_data_clr", 64'(bus.rsp_data), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    void'(exp_rsp_q.pop_back()); void'(exp_wire_q.pop_back()); void'(exp_bits_q.pop_back());
    repeat (200) @(posedge clk);
    #1;
    chk("t5_no_rsp", 64'(rsp_seen), 64'(n_popped));
    slave_pat = {16'hA53C, 24'h0};
    prep(8'h3C, 32'h0000_00F1, 3'd1, 1'b0);
    bus.cmd_valid = 1'b1;
    wait_accept("t5b");
    bus.cmd_valid = 1'b0;
    wait_rsp("t5b");

    // T6: back-to-back frames, loopback when the option is built in
`ifdef PIPELINE_SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    lbv = 1'b1;
`endif
    slave_pat = {16'h0F0F, 24'h0};
    prep(8'h81, 32'h0000_007E, 3'd1, lbv);
    bus.cmd_valid = 1'b1;
    wait_accept("t6a");
    prep(8'h42, 32'h0000_00BD, 3'd1, lbv);
    wait_rsp("t6a");
    wait_accept("t6b");
    bus.cmd_valid = 1'b0;
    wait_rsp("t6b");
    chk("t6_gap_ge_div", 64'(last_gap >= CLK_DIV), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
